lcd_write_ctrl: RTL and testbench

//  HD44780-compatible character-LCD write engine for the DE2 LCD pins (LCD_ON/EN/RS/RW/DATA).

---
 rtl/lcd_write_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_lcd_write_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/lcd_write_ctrl.sv
// HD44780 character-LCD write engine: valid/ready byte writes with hardware setup/enable/hold/busy timing.
// Optional power-on init sequence is enabled by defining LCD_INIT_EN.
module lcd_write_ctrl #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned PULSE_CYC     = 12,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned CMD_WAIT_CYC  = 2000,
  parameter int unsigned CLR_WAIT_CYC  = 82000,
  parameter int unsigned INIT_WAIT_CYC = 750000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       busy_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

  localparam int unsigned MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_B   = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
  localparam int unsigned MAX_C   = (CLR_WAIT_CYC > INIT_WAIT_CYC) ? CLR_WAIT_CYC : INIT_WAIT_CYC;
  localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_WAIT_CYC - 1);
`ifdef LCD_INIT_EN
  localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(INIT_WAIT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
`ifdef LCD_INIT_EN
    S_INIT,
`endif
    S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ready;
  logic             r_busy;
  logic             r_on;
  logic             r_en;
  logic             r_rs;
  logic             r_rw;
  logic [7:0]       r_data;
  logic             w_rs_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_ready_nxt;
  logic             w_en_nxt;
  logic             w_accept;
  logic             w_cnt_zero;
  logic             w_is_clr;
`ifdef LCD_INIT_EN
  logic [2:0]       r_init_idx;
  logic [2:0]       w_init_idx_nxt;
  logic             r_init_done;
  logic             w_init_done_nxt;

  // Power-on instruction sequence: function set x3, display on, clear, entry mode
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h38;
      3'd3:             init_byte = 8'h0C;
      3'd4:             init_byte = 8'h01;
      default:          init_byte = 8'h06;
    endcase
  endfunction
`endif

  assign w_accept   = req_valid_i & r_ready;
  assign w_cnt_zero = (r_cnt == '0);
  // Clear display / return home need the long busy time
  assign w_is_clr   = ~r_rs && (r_data >= 8'h01) && (r_data <= 8'h03);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? '0 : r_cnt - CNT_W'(1);
    w_rs_nxt    = r_rs;
    w_data_nxt  = r_data;
`ifdef LCD_INIT_EN
    w_init_idx_nxt  = r_init_idx;
    w_init_done_nxt = r_init_done;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = LD_SETUP;
          w_rs_nxt    = req_rs_i;
          w_data_nxt  = req_data_i;
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = LD_PULSE;
        end
      end
      S_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = LD_HOLD;
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_is_clr ? LD_CLR : LD_CMD;
        end
      end
      S_WAIT: begin
        if (w_cnt_zero) begin
`ifdef LCD_INIT_EN
          if (!r_init_done && (r_init_idx != 3'd5)) begin
            w_init_idx_nxt = r_init_idx + 3'd1;
            w_rs_nxt       = 1'b0;
            w_data_nxt     = init_byte(r_init_idx + 3'd1);
            w_state_nxt    = S_SETUP;
            w_cnt_nxt      = LD_SETUP;
          end else begin
            w_init_done_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef LCD_INIT_EN
      S_INIT: begin
        if (w_cnt_zero) begin
          w_init_idx_nxt = 3'd0;
          w_rs_nxt       = 1'b0;
          w_data_nxt     = init_byte(3'd0);
          w_state_nxt    = S_SETUP;
          w_cnt_nxt      = LD_SETUP;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_en_nxt    = (w_state_nxt == S_PULSE);
  end

  // State, counter and registered pin drivers; reset forces EN low on the same edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
`ifdef LCD_INIT_EN
      r_state     <= S_INIT;
      r_cnt       <= LD_INIT;
      r_init_idx  <= 3'd0;
      r_init_done <= 1'b0;
`else
      r_state     <= S_IDLE;
      r_cnt       <= '0;
`endif
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_on    <= 1'b0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_rw    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
`ifdef LCD_INIT_EN
      r_init_idx  <= w_init_idx_nxt;
      r_init_done <= w_init_done_nxt;
`endif
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= ~w_ready_nxt;
      r_on    <= 1'b1;
      r_en    <= w_en_nxt;
      r_rs    <= w_rs_nxt;
      r_rw    <= 1'b0;
      r_data  <= w_data_nxt;
    end
  end

  assign req_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign lcd_on_o    = r_on;
  assign lcd_en_o    = r_en;
  assign lcd_rs_o    = r_rs;
  assign lcd_rw_o    = r_rw;
  assign lcd_data_o  = r_data;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Randomised bench for lcd_write_ctrl against a timeline model derived from accept time and write latency.
module tb_lcd_write_ctrl;

  localparam int unsigned S  = 2;
  localparam int unsigned P  = 3;
  localparam int unsigned H  = 1;
  localparam int unsigned CW = 5;
  localparam int unsigned LW = 20;
  localparam int unsigned IW = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       rs;
  logic [7:0] data;
  logic       req_ready_o, busy_o, lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o;
  logic [7:0] lcd_data_o;

  lcd_write_ctrl #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
    .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(LW), .INIT_WAIT_CYC(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(req_ready_o),
    .req_rs_i(rs), .req_data_i(data), .busy_o(busy_o), .lcd_on_o(lcd_on_o),
    .lcd_en_o(lcd_en_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o), .lcd_data_o(lcd_data_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: everything follows from the edge a byte was accepted and its total latency
  bit         m_ready, m_on, m_rs, m_en, m_have, last_acc;
  logic [7:0] m_data;
  int         m_acc, m_lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lat_of(input bit r, input logic [7:0] d);
    int w;
    w = (!r && d >= 8'h01 && d <= 8'h03) ? LW : CW;
    return S + P + H + w;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    last_acc = 0;
    if (rst) begin
      m_ready = 0; m_on = 0; m_rs = 0; m_data = 8'h00; m_have = 0; m_en = 0;
    end else begin
      if (valid && m_ready) begin
        last_acc = 1; m_acc = cyc; m_lat = lat_of(rs, data);
        m_rs = rs; m_data = data; m_have = 1;
      end
      m_on    = 1;
      m_ready = last_acc ? 1'b0 : (!m_have || (cyc - m_acc >= m_lat));
      m_en    = m_have && (cyc - m_acc >= S) && (cyc - m_acc < S + P);
    end
    @(negedge clk);
    chk("ready", req_ready_o, m_ready);
    chk("busy",  busy_o,      !m_ready);
    chk("en",    lcd_en_o,    m_en);
    chk("rs",    lcd_rs_o,    m_rs);
    chk("data",  lcd_data_o,  m_data);
    chk("on",    lcd_on_o,    m_on);
    chk("rw",    lcd_rw_o,    1'b0);
  endtask

  task automatic do_write(input bit r, input logic [7:0] d, input int exp_lat);
    int a, n_en, first_en;
    bit got;
    valid = 1; rs = r; data = d; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      got = last_acc;
    end
    chk("accept", got, 1);
    a = cyc; valid = 0; n_en = 0; first_en = -1;
    for (int i = 0; i < 100; i++) begin
      if (req_ready_o) break;
      if (lcd_en_o) begin
        n_en++;
        if (first_en < 0) first_en = cyc - a;
      end
      step();
    end
    chk("latency", cyc - a, exp_lat);
    chk("en_count", n_en, P);
    chk("en_offset", first_en, S);
  endtask

  initial begin
    int a1;
    bit got, seen;
    rst = 1; valid = 0; rs = 0; data = 8'h00;
    repeat (3) step();
    rst = 0;
    step();
    chk("ready_after_rst", req_ready_o, 1);

    do_write(1, 8'h41, 11);
    do_write(0, 8'h01, 26);
    do_write(0, 8'h80, 11);
    do_write(0, 8'h03, 26);
    do_write(0, 8'h04, 11);
    do_write(0, 8'h00, 11);
    do_write(1, 8'h01, 11);

    // Back-to-back with valid held high
    valid = 1; rs = 1; data = 8'h48; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin step(); got = last_acc; end
    a1 = cyc; data = 8'h49; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin step(); got = last_acc; end
    chk("b2b_gap", cyc - a1, 12);
    valid = 0;
    repeat (15) step();

    // Reset while EN is high
    valid = 1; rs = 1; data = 8'h55; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin step(); got = last_acc; end
    valid = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); seen = lcd_en_o; end
    chk("en_seen", seen, 1);
    rst = 1;
    step();
    chk("rst_en", lcd_en_o, 0);
    repeat (2) step();
    rst = 0;
    step();
    chk("rst_ready", req_ready_o, 1);
    repeat (10) step();

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if (!valid && ($urandom % 3 == 0)) begin
        valid = 1; rs = 1'($urandom % 2);
        data = ($urandom % 4 == 0) ? 8'($urandom % 5) : 8'($urandom % 256);
      end
      rst = ($urandom % 300 == 0);
      step();
      if (last_acc) begin
        if ($urandom % 2 == 0) begin
          rs = 1'($urandom % 2);
          data = ($urandom % 4 == 0) ? 8'($urandom % 5) : 8'($urandom % 256);
        end else begin
          valid = 0;
        end
      end
    end
    rst = 0; valid = 0;
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
